// File: rtl/op1_stager.sv
// Operand-1 pipeline stage: picks register or immediate operand, assembles long
// immediates from prefix instructions, and registers the result behind valid/ready.
module op1_stager #(
    parameter int DW      = 8,
    parameter int IW      = 9,
    parameter int IMM_W   = 5,
    parameter int PFX_W   = 3,
    parameter int MAX_PFX = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [IW-1:0] instr,
    input  logic          is_prefix,
    input  logic [1:0]    op1_sel,
    input  logic [DW-1:0] reg1_value,
    output logic          op1_valid,
    input  logic          op1_ready,
    output logic [DW-1:0] op1,
    output logic          pfx_err
);

    localparam int PFX_TOT = PFX_W * MAX_PFX;
    localparam int LW      = PFX_TOT + IMM_W;
    localparam int XW      = (LW > DW) ? LW : DW;
    localparam int CNT_W   = $clog2(MAX_PFX + 1);

    typedef enum logic [0:0] {IDLE, PFX} state_t;

    state_t             state, state_n;
    logic [PFX_TOT-1:0] pfx_reg, pfx_reg_n;
    logic [CNT_W-1:0]   pfx_cnt, pfx_cnt_n;
    logic [DW-1:0]      op1_n, sel_val;
    logic               op1_valid_n, pfx_err_n;
    logic               accept;
    logic [IMM_W-1:0]   imm;
    logic [XW-1:0]      long_imm;
    logic               unused_instr_bits;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            pfx_reg   <= '0;
            pfx_cnt   <= '0;
            op1       <= '0;
            op1_valid <= 1'b0;
            pfx_err   <= 1'b0;
        end else begin
            state     <= state_n;
            pfx_reg   <= pfx_reg_n;
            pfx_cnt   <= pfx_cnt_n;
            op1       <= op1_n;
            op1_valid <= op1_valid_n;
            pfx_err   <= pfx_err_n;
        end
    end

    always_comb begin
        state_n           = state;
        pfx_reg_n         = pfx_reg;
        pfx_cnt_n         = pfx_cnt;
        op1_n             = op1;
        op1_valid_n       = op1_valid;
        pfx_err_n         = 1'b0;
        unused_instr_bits = ^instr;

        instr_ready = !flush && (!op1_valid || op1_ready);
        accept      = instr_valid && instr_ready;
        imm         = instr[IMM_W-1:0];
        // Zero-extend or truncate the prefix/immediate concatenation to DW.
        long_imm    = XW'({pfx_reg, imm});

        case (op1_sel)
            2'd0:    sel_val = reg1_value;
            2'd1:    sel_val = DW'(imm);
            2'd2:    sel_val = DW'($signed(imm));
            default: sel_val = long_imm[DW-1:0];
        endcase

        if (flush) begin
            op1_valid_n = 1'b0;
            pfx_reg_n   = '0;
            pfx_cnt_n   = '0;
            state_n     = IDLE;
        end else if (accept && is_prefix) begin
            // Newest chunk enters at the bottom; the oldest falls off the top when full.
            pfx_reg_n = PFX_TOT'({pfx_reg, instr[PFX_W-1:0]});
            if (pfx_cnt == CNT_W'(MAX_PFX))
                pfx_err_n = 1'b1;
            else
                pfx_cnt_n = pfx_cnt + CNT_W'(1);
            state_n = PFX;
            if (op1_ready)
                op1_valid_n = 1'b0;
        end else if (accept) begin
            op1_n       = sel_val;
            op1_valid_n = 1'b1;
            if (state == PFX && op1_sel != 2'd3)
                pfx_err_n = 1'b1;
            pfx_reg_n = '0;
            pfx_cnt_n = '0;
            state_n   = IDLE;
        end else if (op1_ready) begin
            op1_valid_n = 1'b0;
        end
    end

endmodule
